nf_uart_receiver: RTL and testbench

UART receive path for the nanoFOX UART peripheral, the counterpart of `nf_uart_transmitter`. It samples the asynchronous `uart_rx` line, recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) using the same `comp` baud divisor as the transmitter, and presents each byte to the controller side with a one-cycle valid strobe. It sits between the UART pad and the UART register block.

---
 rtl/nf_uart_receiver.sv | 145 ++++++++++++++
 tb/tb_nf_uart_receiver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/nf_uart_receiver.sv
// 8N1 UART receiver: 2-FF synchronizer, falling-edge start detect, mid-bit sampling at comp clocks/bit.
// Strobe lands 3+(comp>>1)+9*comp+1 cycles after the line falls; no backpressure, consumer must take the byte on rx_valid.
module nf_uart_receiver (
    input  logic        clk,
    input  logic        reset,
    input  logic        rec_en,
    input  logic [15:0] comp,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    input  logic        uart_rx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rx_m;
    logic        rx_s;
    logic        rx_d;
    logic [15:0] cnt;
    logic [15:0] comp_l;
    logic [15:0] half_cnt;
    logic [15:0] last_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        start_det;
    logic        cnt_clr;
    logic        bit_smp;
    logic        load_data;
    logic        err_set;
    logic        latch_comp;

    // A line held low shows no 1->0 transition, so it cannot re-trigger.
    assign start_det = rx_d & ~rx_s;
    assign half_cnt  = {1'b0, comp_l[15:1]};
    assign last_cnt  = comp_l - 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        bit_smp    = 1'b0;
        load_data  = 1'b0;
        err_set    = 1'b0;
        latch_comp = 1'b0;
        if (!rec_en) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt_clr = 1'b1;
                    if (start_det) begin
                        state_nxt  = START;
                        latch_comp = 1'b1;
                    end
                end
                START: begin
                    if (cnt == half_cnt) begin
                        cnt_clr   = 1'b1;
                        state_nxt = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt == last_cnt) begin
                        cnt_clr = 1'b1;
                        bit_smp = 1'b1;
                        if (bit_idx == 3'd7) begin
                            state_nxt = STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt == last_cnt) begin
                        cnt_clr   = 1'b1;
                        state_nxt = IDLE;
                        load_data = rx_s;
                        err_set   = ~rx_s;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 16'd0;
            comp_l    <= 16'd0;
            bit_idx   <= 3'd0;
            shift     <= 8'd0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= load_data;
            frame_err <= err_set;
            cnt       <= cnt_clr ? 16'd0 : cnt + 16'd1;
            if (latch_comp) begin
                comp_l <= comp;
            end
            if (!rec_en || state == IDLE) begin
                bit_idx <= 3'd0;
            end else if (bit_smp) begin
                bit_idx <= bit_idx + 3'd1;
            end
            // LSB arrives first, so shifting right leaves bit 0 in place after 8 samples.
            if (bit_smp) begin
                shift <= {rx_s, shift[7:1]};
            end
            if (load_data) begin
                rx_data <= shift;
            end
        end
    end

endmodule

// File: tb/tb_nf_uart_receiver.sv
// Bench for nf_uart_receiver: vector table, hand-built corner sequences and random frames
// checked against a frame-level model (good stop -> byte expected, bad stop -> error expected).
module tb_nf_uart_receiver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rec_en = 1'b0;
    logic [15:0] comp = 16'd16;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        uart_rx = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    nf_uart_receiver dut (
        .clk       (clk),
        .reset     (reset),
        .rec_en    (rec_en),
        .comp      (comp),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .uart_rx   (uart_rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_lat(input int lat, input int per);
        int exp;
        exp = 3 + (per >> 1) + 9 * per + 1;
        checks++;
        if (lat < exp - 1 || lat > exp + 1) begin
            failures++;
            $display("FAIL latency: got %0d cycles expected %0d +/-1", lat, exp);
        end
    endtask

    // Strobe monitor
    logic [7:0] valid_q[$];
    int         err_cnt = 0;
    int         valid_cyc = -1;
    logic [7:0] prev_data;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            valid_q.push_back(rx_data);
            valid_cyc = cyc;
        end
        if (frame_err === 1'b1) err_cnt++;
        if (rx_valid === 1'b1 || frame_err === 1'b1)
            chk("strobe_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
        if (reset !== 1'b1 && rx_data !== prev_data)
            chk("rx_data_changes_only_with_valid", {31'd0, rx_valid}, 32'd1);
        prev_data = rx_data;
    end

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int per, input logic stop, input bit scramble);
        uart_rx = 1'b0;
        repeat (per) @(negedge clk);
        if (scramble) comp = 16'($urandom_range(8, 2000));
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (per) @(negedge clk);
        end
        uart_rx = stop;
        repeat (per) @(negedge clk);
        uart_rx = 1'b1;
        if (scramble) comp = 16'(per);
    endtask

    typedef struct {
        logic [7:0] data;
        int         per;
        logic       stop;
        int         exp_valid;
        logic [7:0] exp_data;
        int         exp_err;
    } vec_t;

    vec_t       vecs[7];
    int         n0;
    int         e0;
    int         fall;
    int         per;
    logic       stop;
    logic [7:0] d;
    logic [7:0] last_good;
    logic [7:0] exp_q[$];
    int         exp_err;
    string      msg;
    logic [7:0] b2b[3];

    initial begin
        vecs[0] = '{8'hA5, 16, 1'b1, 1, 8'hA5, 0};
        vecs[1] = '{8'h3C, 16, 1'b0, 0, 8'hA5, 1};
        vecs[2] = '{8'h55, 20, 1'b1, 1, 8'h55, 0};
        vecs[3] = '{8'h00,  8, 1'b1, 1, 8'h00, 0};
        vecs[4] = '{8'hFF,  9, 1'b1, 1, 8'hFF, 0};
        vecs[5] = '{8'h80, 33, 1'b0, 0, 8'hFF, 1};
        vecs[6] = '{8'h01, 33, 1'b1, 1, 8'h01, 0};

        // Reset
        reset = 1'b1; rec_en = 1'b0; uart_rx = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0; rec_en = 1'b1;
        idle(5);

        // Vector table
        for (int v = 0; v < 7; v++) begin
            comp = 16'(vecs[v].per);
            n0 = valid_q.size(); e0 = err_cnt; fall = cyc;
            send_frame(vecs[v].data, vecs[v].per, vecs[v].stop, 1'b0);
            idle(2 * vecs[v].per);
            chk("vec_valid_count", valid_q.size() - n0, vecs[v].exp_valid);
            chk("vec_err_count", err_cnt - e0, vecs[v].exp_err);
            chk("vec_rx_data", {24'd0, rx_data}, {24'd0, vecs[v].exp_data});
            if (vecs[v].exp_valid == 1) chk_lat(valid_cyc - fall, vecs[v].per);
        end
        last_good = 8'h01;

        // Back-to-back message
        msg = "Hello World!";
        comp = 16'd50;
        n0 = valid_q.size(); e0 = err_cnt;
        for (int i = 0; i < msg.len(); i++) send_frame(msg[i], 50, 1'b1, 1'b0);
        idle(100);
        chk("hello_count", valid_q.size() - n0, msg.len());
        for (int i = 0; i < msg.len() && n0 + i < valid_q.size(); i++)
            chk("hello_byte", {24'd0, valid_q[n0 + i]}, {24'd0, msg[i]});
        chk("hello_no_err", err_cnt - e0, 0);
        last_good = 8'h21;

        // Glitch shorter than half a bit
        comp = 16'd434;
        n0 = valid_q.size(); e0 = err_cnt;
        uart_rx = 1'b0;
        repeat (100) @(negedge clk);
        idle(600);
        chk("glitch_no_valid", valid_q.size() - n0, 0);
        chk("glitch_no_err", err_cnt - e0, 0);
        chk("glitch_data_kept", {24'd0, rx_data}, {24'd0, last_good});
        send_frame(8'hA5, 434, 1'b1, 1'b0);
        idle(500);
        chk("after_glitch_count", valid_q.size() - n0, 1);
        chk("after_glitch_data", {24'd0, rx_data}, 32'hA5);
        last_good = 8'hA5;

        // Mid-frame abort during bit 4 of 0xFF: k=0 drops rec_en, k=1 pulses reset
        comp = 16'd64;
        for (int k = 0; k < 2; k++) begin
            n0 = valid_q.size(); e0 = err_cnt;
            uart_rx = 1'b0;
            repeat (64) @(negedge clk);
            uart_rx = 1'b1;
            repeat (4 * 64 + 32) @(negedge clk);
            if (k == 0) rec_en = 1'b0; else reset = 1'b1;
            repeat (5) @(negedge clk);
            rec_en = 1'b1; reset = 1'b0;
            idle(32 + 4 * 64 + 200);
            if (k == 1) last_good = 8'h00;
            chk("abort_no_valid", valid_q.size() - n0, 0);
            chk("abort_no_err", err_cnt - e0, 0);
            chk("abort_data", {24'd0, rx_data}, {24'd0, last_good});
            send_frame(8'h81, 64, 1'b1, 1'b0);
            idle(100);
            chk("after_abort_count", valid_q.size() - n0, 1);
            chk("after_abort_data", {24'd0, rx_data}, 32'h81);
            last_good = 8'h81;
        end

        // Back-to-back with +/-4% baud mismatch at comp=434
        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h5A;
        comp = 16'd434;
        for (int p = 0; p < 2; p++) begin
            per = (p == 0) ? 417 : 451;
            n0 = valid_q.size(); e0 = err_cnt;
            for (int i = 0; i < 3; i++) send_frame(b2b[i], per, 1'b1, 1'b0);
            idle(600);
            chk("b2b_count", valid_q.size() - n0, 3);
            for (int i = 0; i < 3 && n0 + i < valid_q.size(); i++)
                chk("b2b_byte", {24'd0, valid_q[n0 + i]}, {24'd0, b2b[i]});
            chk("b2b_no_err", err_cnt - e0, 0);
        end
        last_good = 8'h5A;

        // Random frames; comp is scrambled mid-frame and must be ignored
        n0 = valid_q.size(); e0 = err_cnt;
        exp_q.delete(); exp_err = 0;
        for (int i = 0; i < 30; i++) begin
            per  = $urandom_range(8, 40);
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            comp = 16'(per);
            send_frame(d, per, stop, 1'b1);
            if (stop) begin
                exp_q.push_back(d);
                last_good = d;
                idle($urandom_range(0, per));
            end else begin
                exp_err++;
                idle(per + $urandom_range(0, per));
            end
        end
        idle(100);
        chk("rand_count", valid_q.size() - n0, exp_q.size());
        for (int i = 0; i < exp_q.size() && n0 + i < valid_q.size(); i++)
            chk("rand_byte", {24'd0, valid_q[n0 + i]}, {24'd0, exp_q[i]});
        chk("rand_err_count", err_cnt - e0, exp_err);
        chk("rand_last_data", {24'd0, rx_data}, {24'd0, last_good});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
